// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: front-panel clock-enable sequencer for the multi-cycle CPU.
// Modes: HALT, single STEP, BURST of N steps, free RUN at a divided rate.
// Optional feature macro: STEP_BKPT_EN (PC breakpoint in RUN/BURST, sticky bkpt_hit).
module cpu_step_ctrl #(
  parameter int DIV_W   = 20,
  parameter int RUN_DIV = 499999,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_pulse,
  input  logic             burst_pulse,
  input  logic [7:0]       burst_len,
  input  logic             run_sw,
  input  logic             halt_req,
  input  logic [31:0]      pc,
  input  logic [31:0]      bkpt_addr,
  output logic             cpu_ce,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] step_cnt,
  output logic             bkpt_hit
);

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    STEP  = 2'd1,
    BURST = 2'd2,
    RUN   = 2'd3
  } mode_t;

  mode_t            state_q, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [7:0]       left_q, left_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             ce_q, ce_n;
  logic             bkpt_q, bkpt_n;
  logic             armed_q, armed_n;
  logic             div_top;
  logic             bkpt_match;

  assign div_top = (div_q == DIV_W'(RUN_DIV));

`ifdef STEP_BKPT_EN
  assign bkpt_match = (pc == bkpt_addr);
`else
  assign bkpt_match = 1'b0;
  logic unused_bkpt_inputs;
  assign unused_bkpt_inputs = ^{pc, bkpt_addr};
`endif

  // Next-state logic: mode transitions, divider, burst countdown and pulse generation.
  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    left_n  = left_q;
    cnt_n   = cnt_q;
    ce_n    = 1'b0;
    bkpt_n  = bkpt_q;
    armed_n = armed_q;

    case (state_q)
      HALT: begin
        if (halt_req) begin
          state_n = HALT;
        end else if (run_sw && armed_q) begin
          state_n = RUN;
          div_n   = '0;
          bkpt_n  = 1'b0;
        end else if (burst_pulse && (burst_len != 8'd0)) begin
          state_n = BURST;
          div_n   = '0;
          left_n  = burst_len;
          bkpt_n  = 1'b0;
        end else if (step_pulse) begin
          state_n = STEP;
          bkpt_n  = 1'b0;
        end
      end

      STEP: begin
        state_n = HALT;
        if (!halt_req) begin
          ce_n = 1'b1;
        end
      end

      BURST: begin
        if (halt_req) begin
          state_n = HALT;
        end else if (div_top) begin
          div_n = '0;
          if (bkpt_match) begin
            state_n = HALT;
            bkpt_n  = 1'b1;
          end else begin
            ce_n   = 1'b1;
            left_n = left_q - 8'd1;
            if (left_q == 8'd1) begin
              state_n = HALT;
            end
          end
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end

      RUN: begin
        if (halt_req) begin
          state_n = HALT;
          armed_n = 1'b0;
        end else if (!run_sw) begin
          state_n = HALT;
        end else if (div_top) begin
          div_n = '0;
          if (bkpt_match) begin
            state_n = HALT;
            bkpt_n  = 1'b1;
            armed_n = 1'b0;
          end else begin
            ce_n = 1'b1;
          end
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end

      default: state_n = HALT;
    endcase

    // Seeing run_sw low re-arms RUN entry after a forced exit.
    if (!run_sw) begin
      armed_n = 1'b1;
    end

    if (ce_n) begin
      cnt_n = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HALT;
      div_q   <= '0;
      left_q  <= '0;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      bkpt_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      left_q  <= left_n;
      cnt_q   <= cnt_n;
      ce_q    <= ce_n;
      bkpt_q  <= bkpt_n;
      armed_q <= armed_n;
    end
  end

  assign cpu_ce   = ce_q;
  assign mode     = state_q;
  assign step_cnt = cnt_q;
  assign bkpt_hit = bkpt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: scoreboard bench for cpu_step_ctrl (RUN_DIV=3, CNT_W=8 so wrap is reachable).
// Honours STEP_BKPT_EN the same way the design does.
module tb_cpu_step_ctrl;

  localparam int DIV_W   = 20;
  localparam int RUN_DIV = 3;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             step_pulse = 1'b0;
  logic             burst_pulse = 1'b0;
  logic [7:0]       burst_len = 8'd0;
  logic             run_sw = 1'b0;
  logic             halt_req = 1'b0;
  logic [31:0]      pc = 32'h0;
  logic [31:0]      bkpt_addr = 32'h10;
  logic             cpu_ce;
  logic [1:0]       mode;
  logic [CNT_W-1:0] step_cnt;
  logic             bkpt_hit;

  typedef struct {
    bit ce;
    int mode;
    int cnt;
    bit bkpt;
  } exp_t;

  exp_t exp_q[$];
  int   assert_cnt = 0;
  int   fail_cnt = 0;
  bit   prev_ce = 1'b0;

  // Reference model state: mode number, ticks to next pulse, bursts left, count, flags.
  int m_mode = 0;
  int m_gap = 0;
  int m_left = 0;
  int m_cnt = 0;
  bit m_bkpt = 1'b0;
  bit m_armed = 1'b1;
  bit m_ce = 1'b0;

  cpu_step_ctrl #(.DIV_W(DIV_W), .RUN_DIV(RUN_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .step_pulse(step_pulse), .burst_pulse(burst_pulse),
    .burst_len(burst_len), .run_sw(run_sw), .halt_req(halt_req), .pc(pc),
    .bkpt_addr(bkpt_addr), .cpu_ce(cpu_ce), .mode(mode), .step_cnt(step_cnt),
    .bkpt_hit(bkpt_hit)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Behavioural model: one call = outputs for the cycle after these inputs.
  function automatic void model_step(bit rst, bit sp, bit bp, int bl, bit rs, bit hr, bit hit);
    bit fire;
    fire = 1'b0;
    m_ce = 1'b0;
    if (rst) begin
      m_mode = 0; m_gap = 0; m_left = 0; m_cnt = 0; m_bkpt = 0; m_armed = 1;
      return;
    end
    if (m_mode == 0) begin
      if (!hr) begin
        if (rs && m_armed) begin
          m_mode = 3; m_gap = RUN_DIV + 1; m_bkpt = 0;
        end else if (bp && bl != 0) begin
          m_mode = 2; m_gap = RUN_DIV + 1; m_left = bl; m_bkpt = 0;
        end else if (sp) begin
          m_mode = 1; m_bkpt = 0;
        end
      end
    end else if (hr) begin
      if (m_mode == 3 && rs) m_armed = 0;
      m_mode = 0;
    end else if (m_mode == 1) begin
      fire = 1; m_mode = 0;
    end else if (m_mode == 3 && !rs) begin
      m_mode = 0;
    end else begin
      m_gap--;
      if (m_gap == 0) begin
        m_gap = RUN_DIV + 1;
        if (hit) begin
          m_bkpt = 1;
          if (m_mode == 3) m_armed = 0;
          m_mode = 0;
        end else begin
          fire = 1;
          if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) m_mode = 0;
          end
        end
      end
    end
    if (!rs) m_armed = 1;
    if (fire) begin
      m_ce = 1;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  endfunction

  task automatic applyStimulus(bit rst, bit sp, bit bp, int bl, bit rs, bit hr);
    exp_t e;
    bit hit;
    reset       = rst;
    step_pulse  = sp;
    burst_pulse = bp;
    burst_len   = 8'(bl);
    run_sw      = rs;
    halt_req    = hr;
    hit = 1'b0;
`ifdef STEP_BKPT_EN
    hit = (pc == bkpt_addr);
`endif
    model_step(rst, sp, bp, bl, rs, hr, hit);
    e.ce = m_ce; e.mode = m_mode; e.cnt = m_cnt; e.bkpt = m_bkpt;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic checkOutput(exp_t e);
    assert_cnt++;
    if (cpu_ce !== e.ce) begin
      fail_cnt++;
      $display("[TB] FAIL cpu_ce @%0t: got %b expected %0b", $time, cpu_ce, e.ce);
    end
    assert_cnt++;
    if (mode !== 2'(e.mode)) begin
      fail_cnt++;
      $display("[TB] FAIL mode @%0t: got %0d expected %0d", $time, mode, e.mode);
    end
    assert_cnt++;
    if (step_cnt !== CNT_W'(e.cnt)) begin
      fail_cnt++;
      $display("[TB] FAIL step_cnt @%0t: got %0d expected %0d", $time, step_cnt, e.cnt);
    end
    assert_cnt++;
    if (bkpt_hit !== e.bkpt) begin
      fail_cnt++;
      $display("[TB] FAIL bkpt_hit @%0t: got %b expected %0b", $time, bkpt_hit, e.bkpt);
    end
    assert_cnt++;
    if ((prev_ce && cpu_ce) !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL ce_back_to_back @%0t: got %b expected 0", $time, prev_ce && cpu_ce);
    end
    prev_ce = cpu_ce;
  endtask

  // Monitor: after each edge, pop every pending expectation and compare against the DUT.
  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  // Stimulus: directed scenarios followed by a randomized phase.
  initial begin : driver
    bit rs;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Single step.
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Burst of 5, then a zero-length burst request.
    applyStimulus(0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 26; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Free run with ignored step/burst pulses, then release.
    for (int i = 0; i < 41; i++) applyStimulus(0, (i % 7) == 3, (i % 11) == 5, 4, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // halt_req on the pulse cycle, then edge-armed re-entry.
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < RUN_DIV * 2 + 1; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Drive step_cnt to all-ones, then one step wraps it to zero.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 255, 0, 0);
    for (int i = 0; i < 255 * (RUN_DIV + 1) + 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a burst.
    applyStimulus(0, 0, 1, 20, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

`ifdef STEP_BKPT_EN
    // Breakpoint in RUN, then a step moves off it.
    pc = 32'h10;
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    pc = 32'h0;
`endif

    // Randomized phase.
    rs = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) rs = ~rs;
      pc = ($urandom_range(0, 3) == 0) ? 32'h10 : 32'h14;
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 15) == 0,
                    int'($urandom_range(0, 6)),
                    rs,
                    $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #4;
    assert_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
